// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ---------------------------------------------------------------------------
// Single-entry issue register between decode and the ALU. Resolves the A/B
// operands (optionally through MEM/WB forwarding), normalises illegal op codes
// to ADD with an illegal flag, and counts accepted illegal ops.
//
// Build option:
//   ALU_ISSUE_FWD_EN  defined   -> operands forwarded from MEM (priority) and
//                                  WB, and re-checked while the entry is held.
//                     undefined -> fwd_* inputs ignored; operands come straight
//                                  from the register-file / immediate inputs.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              decode handshake
//   in_op, in_rs_idx, in_rt_idx,   decoded op and register indices
//   in_rd_idx
//   in_rs_val, in_rt_val, in_imm,  register-file read data, immediate,
//   in_use_imm                     B-from-immediate select
//   fwd_mem_*, fwd_wb_*            forwarding write ports (MEM, WB)
//   out_valid/out_ready            ALU handshake
//   out_op, out_A, out_B,          issued op, operands, destination,
//   out_rd_idx, out_illegal        illegal-op flag
//   flush                          drop held entry and same-cycle input
//   err_cnt                        saturating count of accepted illegal ops
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs_idx,
  input  logic [4:0]        in_rt_idx,
  input  logic [4:0]        in_rd_idx,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  // forwarding
  input  logic              fwd_mem_we,
  input  logic [4:0]        fwd_mem_idx,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_we,
  input  logic [4:0]        fwd_wb_idx,
  input  logic [DATA_W-1:0] fwd_wb_data,
  // ALU side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [4:0]        out_rd_idx,
  output logic              out_illegal,
  // control / status
  input  logic              flush,
  output logic [7:0]        err_cnt
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Pipeline register (stage p0 feeds the ALU directly)
  logic              vld_p0;
  logic              ill_p0;
  logic [3:0]        op_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [4:0]        rd_p0;
  logic [7:0]        err_cnt_q;

  logic              accept;
  logic              hold;
  logic              in_legal;
  logic [DATA_W-1:0] a_new;
  logic [DATA_W-1:0] b_new;
  logic [DATA_W-1:0] a_ref;
  logic [DATA_W-1:0] b_ref;

  assign in_ready = (!vld_p0 || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign hold     = vld_p0 && !out_ready;
  assign in_legal = op_legal(in_op);

`ifdef ALU_ISSUE_FWD_EN
  // Source indices of the held entry, kept so the operands can be refreshed
  // from writers that complete while the ALU is stalled.
  logic [4:0] rs_p0;
  logic [4:0] rt_p0;
  logic       use_imm_p0;

  // Index 0 is hard-wired zero in the register file and must never forward.
  function automatic logic fwd_hit(input logic       we,
                                   input logic [4:0] widx,
                                   input logic [4:0] ridx);
    return we && (widx == ridx) && (ridx != 5'd0);
  endfunction

  always_comb begin
    a_new = in_rs_val;
    if (fwd_hit(fwd_mem_we, fwd_mem_idx, in_rs_idx))
      a_new = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_idx, in_rs_idx))
      a_new = fwd_wb_data;

    b_new = in_rt_val;
    if (in_use_imm)
      b_new = in_imm;
    else if (fwd_hit(fwd_mem_we, fwd_mem_idx, in_rt_idx))
      b_new = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_idx, in_rt_idx))
      b_new = fwd_wb_data;

    // Held operands only change on a forwarding match; otherwise keep.
    a_ref = a_p0;
    if (fwd_hit(fwd_mem_we, fwd_mem_idx, rs_p0))
      a_ref = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_idx, rs_p0))
      a_ref = fwd_wb_data;

    b_ref = b_p0;
    if (use_imm_p0)
      b_ref = b_p0;
    else if (fwd_hit(fwd_mem_we, fwd_mem_idx, rt_p0))
      b_ref = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_idx, rt_p0))
      b_ref = fwd_wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_p0      <= '0;
      rt_p0      <= '0;
      use_imm_p0 <= 1'b0;
    end else if (accept) begin
      rs_p0      <= in_rs_idx;
      rt_p0      <= in_rt_idx;
      use_imm_p0 <= in_use_imm;
    end
  end
`else
  // Forwarding disabled: these inputs are intentionally left unconnected.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_we, fwd_mem_idx, fwd_mem_data,
                        fwd_wb_we, fwd_wb_idx, fwd_wb_data,
                        in_rs_idx, in_rt_idx};

  always_comb begin
    a_new = in_rs_val;
    b_new = in_use_imm ? in_imm : in_rt_val;
    a_ref = a_p0;
    b_ref = b_p0;
  end
`endif

  // Stage p0 register: flush beats accept beats transfer beats hold-refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      ill_p0    <= 1'b0;
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      rd_p0     <= '0;
      err_cnt_q <= '0;
    end else begin
      if (flush) begin
        vld_p0 <= 1'b0;
      end else if (accept) begin
        vld_p0 <= 1'b1;
        ill_p0 <= !in_legal;
        op_p0  <= in_legal ? in_op : OP_ADD;
        a_p0   <= a_new;
        b_p0   <= b_new;
        rd_p0  <= in_rd_idx;
      end else if (vld_p0 && out_ready) begin
        vld_p0 <= 1'b0;
      end else if (hold) begin
        a_p0 <= a_ref;
        b_p0 <= b_ref;
      end

      if (accept && !in_legal)
        err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign out_valid   = vld_p0;
  assign out_illegal = ill_p0;
  assign out_op      = op_p0;
  assign out_A       = a_p0;
  assign out_B       = b_p0;
  assign out_rd_idx  = rd_p0;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed scenarios followed by randomized traffic, all compared against a
// transaction-level model of the issue slot kept in this file.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx;
  logic [31:0] in_rs_val, in_rt_val, in_imm;
  logic        in_use_imm;
  logic        fwd_mem_we;
  logic [4:0]  fwd_mem_idx;
  logic [31:0] fwd_mem_data;
  logic        fwd_wb_we;
  logic [4:0]  fwd_wb_idx;
  logic [31:0] fwd_wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_A, out_B;
  logic [4:0]  out_rd_idx;
  logic        out_illegal;
  logic        flush;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_idx(fwd_mem_idx), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_idx(fwd_wb_idx), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_A(out_A), .out_B(out_B), .out_rd_idx(out_rd_idx),
    .out_illegal(out_illegal), .flush(flush), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what the ALU should currently be seeing.
  logic        m_vld;
  logic [3:0]  m_op;
  logic        m_ill;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd, m_rs, m_rt;
  logic        m_immb;
  int          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value a reader of register r should see this cycle.
  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] dflt);
    if (FWD && r != 5'd0 && fwd_mem_we && fwd_mem_idx == r) return fwd_mem_data;
    if (FWD && r != 5'd0 && fwd_wb_we && fwd_wb_idx == r) return fwd_wb_data;
    return dflt;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_op = 0; m_ill = 0; m_a = 0; m_b = 0; m_rd = 0;
    m_rs = 0; m_rt = 0; m_immb = 0; m_err = 0;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsv,
                       input logic [31:0] rtv, input logic [31:0] imm, input logic ui);
    in_valid = v; in_op = op; in_rs_idx = rs; in_rt_idx = rt; in_rd_idx = rd;
    in_rs_val = rsv; in_rt_val = rtv; in_imm = imm; in_use_imm = ui;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] midx, input logic [31:0] mdat,
                         input logic wwe, input logic [4:0] widx, input logic [31:0] wdat);
    fwd_mem_we = mwe; fwd_mem_idx = midx; fwd_mem_data = mdat;
    fwd_wb_we = wwe; fwd_wb_idx = widx; fwd_wb_data = wdat;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_vld);
    chk("err_cnt", err_cnt, m_err);
    if (m_vld) begin
      chk("out_op", out_op, m_op);
      chk("out_illegal", out_illegal, m_ill);
      chk("out_A", out_A, m_a);
      chk("out_B", out_B, m_b);
      chk("out_rd_idx", out_rd_idx, m_rd);
    end
  endtask

  // One clock: check in_ready for the current inputs, advance the model,
  // clock the DUT and compare outputs shortly after the edge.
  task automatic step();
    logic rdy, acc;
    #1;
    rdy = (!m_vld || out_ready) && !flush;
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (flush) begin
      m_vld = 0;
    end else if (acc) begin
      m_vld  = 1;
      m_ill  = !(in_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111});
      m_op   = m_ill ? 4'b0010 : in_op;
      m_a    = mfwd(in_rs_idx, in_rs_val);
      m_b    = in_use_imm ? in_imm : mfwd(in_rt_idx, in_rt_val);
      m_rd   = in_rd_idx;
      m_rs   = in_rs_idx;
      m_rt   = in_rt_idx;
      m_immb = in_use_imm;
    end else if (m_vld && out_ready) begin
      m_vld = 0;
    end else if (m_vld) begin
      m_a = mfwd(m_rs, m_a);
      if (!m_immb) m_b = mfwd(m_rt, m_b);
    end
    if (acc && m_ill && !flush && m_err < 255) m_err++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [3:0] ops [8];
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF, 4'h3, 4'h9};

    // Reset state, before any clock edge
    rst_n = 1'b0; out_ready = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_A", out_A, 0);
    chk("rst_out_B", out_B, 0);
    chk("rst_out_rd", out_rd_idx, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ADD then SUB
    out_ready = 1;
    drive(1, 4'b0010, 5'd1, 5'd2, 5'd10, 32'd5, 32'd3, 0, 0);
    step();
    chk("b2b_op0", out_op, 4'b0010);
    chk("b2b_A0", out_A, 32'd5);
    chk("b2b_B0", out_B, 32'd3);
    drive(1, 4'b0110, 5'd1, 5'd2, 5'd11, 32'd9, 32'd4, 0, 0);
    step();
    chk("b2b_op1", out_op, 4'b0110);
    chk("b2b_A1", out_A, 32'd9);
    chk("b2b_B1", out_B, 32'd4);
    chk("b2b_in_ready", in_ready, 1);
    in_valid = 0;
    step();

    // Forwarding priority and index-0 suppression
    drive(1, 4'b0000, 5'd7, 5'd0, 5'd1, 32'd1, 32'd2, 0, 0);
    set_fwd(1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB);
    step();
    chk("fwd_prio_A", out_A, FWD ? 32'hAA : 32'h1);
    drive(1, 4'b0000, 5'd0, 5'd0, 5'd1, 32'h12, 32'd2, 0, 0);
    set_fwd(1, 5'd0, 32'hAA, 0, 0, 0);
    step();
    chk("fwd_r0_A", out_A, 32'h12);
    in_valid = 0;
    set_fwd(0, 0, 0, 0, 0, 0);
    step();

    // Stall refresh of a register operand
    out_ready = 0;
    drive(1, 4'b0001, 5'd4, 5'd3, 5'd2, 32'h1, 32'h10, 0, 0);
    step();
    in_valid = 0;
    set_fwd(1, 5'd3, 32'h55, 0, 0, 0);
    step();
    chk("refresh_B", out_B, FWD ? 32'h55 : 32'h10);
    set_fwd(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    step();
    // Immediate operand is never refreshed
    out_ready = 0;
    drive(1, 4'b0001, 5'd4, 5'd3, 5'd2, 32'h1, 32'h10, 32'h20, 1);
    step();
    in_valid = 0;
    set_fwd(1, 5'd3, 32'h55, 0, 0, 0);
    step();
    chk("imm_hold_B", out_B, 32'h20);
    set_fwd(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    step();

    // Illegal ops and counter saturation
    drive(1, 4'hF, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("ill_cnt3", err_cnt, 8'd3);
    chk("ill_op", out_op, 4'b0010);
    chk("ill_flag", out_illegal, 1);
    for (int i = 0; i < 300; i++) step();
    chk("ill_sat", err_cnt, 8'd255);
    in_valid = 0;
    step();

    // Flush with a held entry and a pending input
    out_ready = 0;
    drive(1, 4'b0111, 5'd1, 5'd2, 5'd4, 32'd7, 32'd8, 0, 0);
    step();
    drive(1, 4'b0000, 5'd1, 5'd2, 5'd5, 32'd1, 32'd1, 0, 0);
    out_ready = 1;
    flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    chk("flush_out_valid", out_valid, 0);
    flush = 0;
    in_valid = 0;
    step();

    // Asynchronous reset while an entry is held
    out_ready = 0;
    drive(1, 4'hC, 5'd1, 5'd2, 5'd6, 32'd3, 32'd4, 0, 0);
    step();
    in_valid = 0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_err", err_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 7)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom, $urandom_range(0, 3) == 0);
      set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have decode-side ports: in_valid in 1; in_ready out 1; in_op in 4 ALU op code; in_rs_idx, in_rt_idx, in_rd_idx in 5 each; in_rs_val, in_rt_val in 32 each, register-file read data; in_imm in 32; in_use_imm in 1 (B from imm).
REQ-003 SHALL have forwarding ports: fwd_mem_we in 1, fwd_mem_idx in 5, fwd_mem_data in 32; fwd_wb_we in 1, fwd_wb_idx in 5, fwd_wb_data in 32.
REQ-004 SHALL have ALU-side ports: out_valid out 1; out_ready in 1; out_op out 4; out_A, out_B out 32; out_rd_idx out 5; out_illegal out 1.
REQ-005 SHALL have control/status ports: flush in 1; err_cnt out 8, count of illegal ops accepted.

Function
REQ-006 Single-entry pipeline register between decode and ALU; no combinational path from in_* data to out_*.
REQ-007 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-008 Accept = in_valid && in_ready; on accept, register captures op, rd_idx, resolved A, resolved B; out_valid=1 next cycle.
REQ-009 Transfer = out_valid && out_ready; transfer without accept clears out_valid; simultaneous transfer+accept loads the new entry (back-to-back, 1 op/cycle).
REQ-010 Latency in_valid accept -> out_valid: exactly 1 cycle.
REQ-011 out_* data SHALL remain stable while out_valid && !out_ready, except operand refresh per REQ-014.
REQ-012 Operand resolution: A = fwd(rs); B = in_use_imm ? in_imm : fwd(rt).
REQ-013 fwd(r): if fwd_mem_we && fwd_mem_idx==r && r!=0 -> fwd_mem_data; else if fwd_wb_we && fwd_wb_idx==r && r!=0 -> fwd_wb_data; else register-file value. MEM has priority over WB.
REQ-014 While holding (out_valid && !out_ready), held rs/rt indices SHALL be re-checked each cycle; a forwarding match overwrites the held operand (immediate B never overwritten).
REQ-015 Legal ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT; any other captured op drives out_op=0010 (ADD) and out_illegal=1 with the entry.
REQ-016 err_cnt SHALL increment on each accepted illegal op, saturating at 255.
REQ-017 flush SHALL clear out_valid next edge, drop any same-cycle input (in_ready=0), override transfer; data registers need not clear.
REQ-018 Index 0 SHALL never forward, even if a writer targets 0.

Reset
REQ-019 rst_n low SHALL asynchronously force out_valid=0, out_illegal=0, out_op=0, out_A=0, out_B=0, out_rd_idx=0, err_cnt=0.
REQ-020 Reset deassertion SHALL be followed by normal operation on the next rising edge; an entry held at reset is lost.

Configuration
REQ-021 Macro ALU_ISSUE_FWD_EN defined: forwarding per REQ-013/REQ-014.
REQ-022 ALU_ISSUE_FWD_EN undefined: fwd_* inputs ignored, A/B taken directly from in_rs_val/in_rt_val/in_imm, no refresh; all other behaviour identical.

Verification
REQ-023 Reset mid-hold: out_valid=1, out_ready=0, rst_n pulses low -> out_valid=0, err_cnt=0 immediately, without clock edge.
REQ-024 Back-to-back: out_ready=1, ADD(A=5,B=3) then SUB(A=9,B=4) on consecutive cycles -> out_valid=1 two cycles, out_op 0010 then 0110, operands correct, in_ready stays 1.
REQ-025 Forward priority (FWD_EN): rs=7, in_rs_val=1, MEM writes r7=0xAA, WB writes r7=0xBB same cycle -> out_A=0xAA; rs=0 with MEM writing r0 -> out_A=in_rs_val.
REQ-026 Stall refresh (FWD_EN): entry held with rt=3, B=0x10, out_ready=0; next cycle MEM writes r3=0x55 -> out_B=0x55; with in_use_imm=1, imm=0x20 -> out_B stays 0x20.
REQ-027 Illegal op: accept op=1111 three times, then 300 more -> out_op=0010, out_illegal=1 each; err_cnt=3 then saturates at 255.
REQ-028 Flush: in_valid=1 and out_valid=1 with flush=1 -> in_ready=0, next cycle out_valid=0, no transfer counted.
